wide_add_seq: RTL and testbench

Multi-cycle wide-operand add/subtract sequencer that sits directly upstream of the team's N-bit ripple-carry adder. It splits WORDS×N-bit operands into N-bit slices and presents one slice per cycle to the combinational adder, least significant first. It chains the adder's carry-out back into carry-in across cycles and assembles the full-width result with carry and signed-overflow flags. The adder is instantiated beside this block by the parent, and only its port signals cross the boundary.

---
 rtl/wide_add_pkg.sv | 16 +
 rtl/wide_add_seq.sv | 139 +++++++++++++
 tb/tb_wide_add_seq.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the wide-operand add/subtract sequencer.
// The sequencer drives an external N-bit adder one slice per cycle.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index; a single-slice configuration still needs one bit.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq.sv
// Multi-cycle wide add/subtract: feeds N-bit slices, LSB first, to an external
// ripple-carry adder, chains the carry across cycles and assembles the result.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sub,
  input  logic [N*WORDS-1:0]   in_a,
  input  logic [N*WORDS-1:0]   in_b,
  output logic [N-1:0]         adder_a,
  output logic [N-1:0]         adder_b,
  output logic                 adder_cin,
  input  logic [N-1:0]         adder_sum,
  input  logic                 adder_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   out_result,
  output logic                 out_carry,
  output logic                 out_overflow
);

  localparam int W  = N * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;     // effective b: already inverted for subtract
  logic            sub_reg;
  logic            carry_reg;
  logic [IW-1:0]   idx;

  logic [N-1:0]    a_slice;
  logic [N-1:0]    b_slice;
  logic            ovf_next;

  // Slice select: a constant-bounded loop keeps every part-select static.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    a_slice = '0;
    b_slice = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == IW'(w)) begin
        a_slice = a_reg[w*N +: N];
        b_slice = b_reg[w*N +: N];
      end
    end
  end

  // The adder sees zeros outside RUN so it idles quietly between operations.
  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (state == RUN) begin
      adder_a   = a_slice;
      adder_b   = b_slice;
      adder_cin = (idx == '0) ? sub_reg : carry_reg;
    end
  end

  // Signed overflow: operands agree in sign but the top slice's sum does not.
  assign ovf_next = (a_reg[W-1] == b_reg[W-1]) && (adder_sum[N-1] != a_reg[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      sub_reg      <= 1'b0;
      carry_reg    <= 1'b0;
      idx          <= '0;
      out_result   <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_sub ? ~in_b : in_b;
            sub_reg  <= in_sub;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx == IW'(w)) out_result[w*N +: N] <= adder_sum;
          end
          carry_reg <= adder_cout;
          if (idx == LAST_IDX) begin
            out_carry    <= adder_cout;
            out_overflow <= ovf_next;
            idx          <= '0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // A stalled result must not move until the consumer takes it.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_result)
                                   && $stable(out_carry) && $stable(out_overflow)));

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid));

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq with a behavioural 16-bit adder attached
// and a full-width arithmetic reference model.
module tb_wide_add_seq;

  localparam int N     = 16;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           in_sub;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [N-1:0]   adder_a;
  logic [N-1:0]   adder_b;
  logic           adder_cin;
  logic [N-1:0]   adder_sum;
  logic           adder_cout;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_result;
  logic           out_carry;
  logic           out_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Attached N-bit adder.
  logic [N:0] adder_full;
  assign adder_full = {1'b0, adder_a} + {1'b0, adder_b} + {{N{1'b0}}, adder_cin};
  assign adder_sum  = adder_full[N-1:0];
  assign adder_cout = adder_full[N];

  wide_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sub       (in_sub),
    .in_a         (in_a),
    .in_b         (in_b),
    .adder_a      (adder_a),
    .adder_b      (adder_b),
    .adder_cin    (adder_cin),
    .adder_sum    (adder_sum),
    .adder_cout   (adder_cout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow)
  );

  // Reference: plain 64-bit arithmetic; carry = unsigned carry-out (add) or
  // "no borrow" (sub); overflow = signed result out of 64-bit range.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] r, output logic c, output logic o);
    logic signed [W:0] sa, sb, sr;
    logic [W:0] ur;
    sa = {a[W-1], a};
    sb = {b[W-1], b};
    if (sub) begin
      sr = sa - sb;
      r  = a - b;
      c  = (a >= b);
    end else begin
      sr = sa + sb;
      ur = {1'b0, a} + {1'b0, b};
      r  = ur[W-1:0];
      c  = ur[W];
    end
    o = (sr[W] != sr[W-1]);
  endtask

  // Issue one request from IDLE, wait (bounded) for the result, then take it.
  // lat = edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] res, output logic c, output logic o,
                        output int lat);
    lat = -1;
    res = '0;
    c   = 1'b0;
    o   = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) begin
      res = out_result;
      c   = out_carry;
      o   = out_overflow;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_carry, out_overflow, adder_cin} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 10000",
               {in_ready, out_valid, out_carry, out_overflow, adder_cin});
    end
    total++;
    if (out_result !== '0) begin
      bad++;
      $display("FAIL reset_result: got %h want 0", out_result);
    end
    total++;
    if ({adder_a, adder_b} !== '0) begin
      bad++;
      $display("FAIL reset_adder: got %h want 0", {adder_a, adder_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [5];
    logic [W-1:0] res;
    logic c, o;
    int lat;
    vecs[0] = '{a: 64'h0000_0000_0000_FFFF, b: 64'h1, sub: 1'b0,
                r: 64'h0000_0000_0001_0000, c: 1'b0, o: 1'b0};
    vecs[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h1, sub: 1'b0,
                r: 64'h0, c: 1'b1, o: 1'b0};
    vecs[2] = '{a: 64'h5, b: 64'h7, sub: 1'b1,
                r: 64'hFFFF_FFFF_FFFF_FFFE, c: 1'b0, o: 1'b0};
    vecs[3] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'h1, sub: 1'b0,
                r: 64'h8000_0000_0000_0000, c: 1'b0, o: 1'b1};
    vecs[4] = '{a: 64'h8000_0000_0000_0000, b: 64'h1, sub: 1'b1,
                r: 64'h7FFF_FFFF_FFFF_FFFF, c: 1'b1, o: 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, res, c, o, lat);
      total++;
      if (res !== vecs[i].r) begin
        bad++;
        $display("FAIL directed%0d_result: got %h want %h", i, res, vecs[i].r);
      end
      total++;
      if ({c, o} !== {vecs[i].c, vecs[i].o}) begin
        bad++;
        $display("FAIL directed%0d_flags: got c=%b o=%b want c=%b o=%b",
                 i, c, o, vecs[i].c, vecs[i].o);
      end
      total++;
      if (lat !== WORDS) begin
        bad++;
        $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, WORDS);
      end
    end
  endtask

  task automatic test_sub_slices();
    int seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 64'h5;
    in_b     = 64'h7;
    in_sub   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({adder_a, adder_b, adder_cin} !== {16'h0005, 16'hFFF8, 1'b1}) begin
      bad++;
      $display("FAIL sub_slice0: got a=%h b=%h cin=%b want 0005 fff8 1",
               adder_a, adder_b, adder_cin);
    end
    @(negedge clk);
    total++;
    if ({adder_a, adder_b, adder_cin} !== {16'h0000, 16'hFFFF, 1'b0}) begin
      bad++;
      $display("FAIL sub_slice1: got a=%h b=%h cin=%b want 0000 ffff 0",
               adder_a, adder_b, adder_cin);
    end
    seen = 0;
    for (int k = 0; k < 64; k++) begin
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (seen != 1 || {adder_a, adder_b, adder_cin} !== '0) begin
      bad++;
      $display("FAIL sub_done_adder_idle: got seen=%0d adder=%h want 1 0",
               seen, {adder_a, adder_b, adder_cin});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res, er;
    logic sub, c, o, ec, eo;
    int lat;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        1: begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255)); end
        2: begin a = '1 - W'($urandom_range(0, 3)); b = W'($urandom_range(0, 3)); end
        default: begin
          a = {1'b0, {(W-1){1'b1}}} ^ W'($urandom_range(0, 1));
          b = {1'b1, {(W-1){1'b0}}} | W'($urandom_range(0, 1));
        end
      endcase
      sub = 1'($urandom_range(0, 1));
      model(a, b, sub, er, ec, eo);
      run_op(a, b, sub, res, c, o, lat);
      total++;
      if (res !== er || {c, o} !== {ec, eo} || lat !== WORDS) begin
        bad++;
        $display("FAIL random%0d: got r=%h c=%b o=%b lat=%0d want r=%h c=%b o=%b lat=%0d (a=%h b=%h sub=%b)",
                 i, res, c, o, lat, er, ec, eo, WORDS, a, b, sub);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a1, b1, a2, b2, er1, er2, res;
    logic ec1, eo1, ec2, eo2, c, o;
    int lat;
    a1 = {$urandom, $urandom};
    b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    model(a1, b1, 1'b0, er1, ec1, eo1);
    model(a2, b2, 1'b1, er2, ec2, eo2);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a1;
    in_b = b1;
    in_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 64; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_a = a2;
    in_b = b2;
    in_sub = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== er1
          || {out_carry, out_overflow} !== {ec1, eo1}) begin
        bad++;
        $display("FAIL stall%0d: got v=%b rdy=%b r=%h c=%b o=%b want 1 0 %h %b %b",
                 i, out_valid, in_ready, out_result, out_carry, out_overflow, er1, ec1, eo1);
      end
      if (i == 3) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release_idle: got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_new_accept: got rdy=%b want 0", in_ready);
    end
    lat = -1;
    for (int k = 0; k < 64; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    res = out_result;
    c = out_carry;
    o = out_overflow;
    total++;
    if (res !== er2 || {c, o} !== {ec2, eo2} || lat !== WORDS) begin
      bad++;
      $display("FAIL stall_second_op: got r=%h c=%b o=%b lat=%0d want %h %b %b %0d",
               res, c, o, lat, er2, ec2, eo2, WORDS);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] res;
    logic c, o;
    int lat, spurious;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 64'hFFFF_FFFF_FFFF_FFFF;
    in_b = 64'h1;
    in_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_carry, out_overflow, adder_cin} !== 5'b10000
        || out_result !== '0 || {adder_a, adder_b} !== '0) begin
      bad++;
      $display("FAIL midrun_reset_values: got flags=%b r=%h adder=%h want 10000 0 0",
               {in_ready, out_valid, out_carry, out_overflow, adder_cin}, out_result,
               {adder_a, adder_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
    end
    total++;
    if (spurious != 0) begin
      bad++;
      $display("FAIL midrun_no_valid: got %0d bad cycles want 0", spurious);
    end
    run_op(64'h1234, 64'h1, 1'b0, res, c, o, lat);
    total++;
    if (res !== 64'h1235 || {c, o} !== 2'b00 || lat !== WORDS) begin
      bad++;
      $display("FAIL midrun_next_op: got r=%h c=%b o=%b lat=%0d want 1235 0 0 %0d",
               res, c, o, lat, WORDS);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, er;
    logic ec, eo;
    int idle_at [$];
    int valids;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    model(a, b, 1'b0, er, ec, eo);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sub = 1'b0;
    out_ready = 1'b1;
    valids = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_ready) idle_at.push_back(cyc);
      if (out_valid) begin
        valids++;
        total++;
        if (out_result !== er || {out_carry, out_overflow} !== {ec, eo}) begin
          bad++;
          $display("FAIL b2b_result: got %h c=%b o=%b want %h %b %b",
                   out_result, out_carry, out_overflow, er, ec, eo);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (valids < 6 || idle_at.size() < 6) begin
      bad++;
      $display("FAIL b2b_count: got valids=%0d idles=%0d want >=6 each", valids, idle_at.size());
    end
    for (int i = 1; i < idle_at.size(); i++) begin
      total++;
      if (idle_at[i] - idle_at[i-1] != WORDS + 2) begin
        bad++;
        $display("FAIL b2b_spacing%0d: got %0d want %0d", i, idle_at[i] - idle_at[i-1], WORDS + 2);
      end
    end
    for (int k = 0; k < 20; k++) begin
      if (in_ready && !out_valid) break;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #2 rst_n  = 1'b0;
    test_reset();
    test_directed();
    test_sub_slices();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
